// File: rtl/kahn_sequencer_if.sv
// Sequencer-side bundle: control, indegree list port, adjacency query/reply channels and sorted stream.
// master = kahn_sequencer, slave = surrounding indegree list / adjacency map / consumer.
interface kahn_sequencer_if #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES)
);
    logic                  start;
    logic [NODE_WIDTH:0]   node_cnt;

    logic [NODE_WIDTH-1:0] indeg_node;
    logic                  indeg_dec;
    logic [NODE_WIDTH-1:0] indeg_degree;

    logic                  query_valid;
    logic                  query_ready;
    logic [NODE_WIDTH-1:0] query_data;

    logic                  reply_valid;
    logic                  reply_ready;
    logic [NODE_WIDTH-1:0] reply_data;
    logic                  reply_last;
    logic                  reply_empty;

    logic                  sorted_valid;
    logic [NODE_WIDTH-1:0] sorted_node;
    logic                  sorted_last;

    logic                  done;
    logic                  cycle_detected;

    modport master (
        input  start, node_cnt, indeg_degree, query_ready,
               reply_valid, reply_data, reply_last, reply_empty,
        output indeg_node, indeg_dec, query_valid, query_data, reply_ready,
               sorted_valid, sorted_node, sorted_last, done, cycle_detected
    );

    modport slave (
        output start, node_cnt, indeg_degree, query_ready,
               reply_valid, reply_data, reply_last, reply_empty,
        input  indeg_node, indeg_dec, query_valid, query_data, reply_ready,
               sorted_valid, sorted_node, sorted_last, done, cycle_detected
    );
endinterface

// File: rtl/kahn_sequencer.sv
// Kahn topological-sort sequencer: sweeps indegrees for sources, pops the ready queue, decrements successors.
// Sweep takes node_cnt cycles; each node costs 1 POP + query wait + 1 cycle per reply beat; sorted stream has no backpressure.
module kahn_sequencer #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
    input logic              clk,
    input logic              rst,
    kahn_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_POP,
        S_QUERY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [NODE_WIDTH-1:0] queue_mem [MAX_NODES];
    logic [NODE_WIDTH:0]   wr_ptr, rd_ptr;
    logic [NODE_WIDTH:0]   emit_cnt;
    logic [NODE_WIDTH:0]   node_cnt_q;
    logic [NODE_WIDTH-1:0] scan;
    logic [NODE_WIDTH-1:0] query_data_q;

    logic                  q_empty;
    logic [NODE_WIDTH-1:0] head;
    logic                  start_ok;
    logic                  beat;
    logic                  dec_beat;
    logic                  sweep_end;
    logic                  push_en;
    logic [NODE_WIDTH-1:0] push_dat;
    logic                  pop_en;

    assign q_empty   = (wr_ptr == rd_ptr);
    assign head      = queue_mem[rd_ptr[NODE_WIDTH-1:0]];
    assign start_ok  = bus.start && (state == S_IDLE || state == S_DONE);
    assign beat      = (state == S_DRAIN) && bus.reply_valid;
    assign dec_beat  = beat && !bus.reply_empty;
    assign sweep_end = ({1'b0, scan} == node_cnt_q - (NODE_WIDTH+1)'(1));
    assign pop_en    = (state == S_POP) && !q_empty;

    // A successor becomes ready on the beat that takes its degree from 1 to 0,
    // so duplicate edges still push it exactly once.
    always_comb begin
        push_en  = 1'b0;
        push_dat = '0;
        if (state == S_SWEEP) begin
            push_en  = (bus.indeg_degree == '0);
            push_dat = scan;
        end else if (dec_beat) begin
            push_en  = (bus.indeg_degree == NODE_WIDTH'(1));
            push_dat = bus.reply_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_nxt = (bus.node_cnt == '0) ? S_DONE : S_SWEEP;
                end
            end
            S_SWEEP: if (sweep_end) state_nxt = S_POP;
            S_POP:   state_nxt = q_empty ? S_DONE : S_QUERY;
            S_QUERY: if (bus.query_ready) state_nxt = S_DRAIN;
            S_DRAIN: if (beat && bus.reply_last) state_nxt = S_POP;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.indeg_node     = '0;
        bus.indeg_dec      = dec_beat;
        bus.query_valid    = (state == S_QUERY);
        bus.query_data     = query_data_q;
        bus.reply_ready    = (state == S_DRAIN);
        bus.sorted_valid   = pop_en;
        bus.sorted_node    = pop_en ? head : '0;
        bus.sorted_last    = pop_en && (emit_cnt + (NODE_WIDTH+1)'(1) == node_cnt_q);
        bus.done           = (state == S_DONE);
        bus.cycle_detected = (state == S_DONE) && (emit_cnt != node_cnt_q);
        if (state == S_SWEEP) begin
            bus.indeg_node = scan;
        end else if (dec_beat) begin
            bus.indeg_node = bus.reply_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            emit_cnt     <= '0;
            node_cnt_q   <= '0;
            scan         <= '0;
            query_data_q <= '0;
        end else if (start_ok) begin
            node_cnt_q <= bus.node_cnt;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            emit_cnt   <= '0;
            scan       <= '0;
        end else begin
            if (state == S_SWEEP) begin
                scan <= scan + NODE_WIDTH'(1);
            end
            if (push_en) begin
                wr_ptr <= wr_ptr + (NODE_WIDTH+1)'(1);
            end
            if (pop_en) begin
                rd_ptr       <= rd_ptr + (NODE_WIDTH+1)'(1);
                emit_cnt     <= emit_cnt + (NODE_WIDTH+1)'(1);
                query_data_q <= head;
            end
        end
    end

    // Queue storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            queue_mem[wr_ptr[NODE_WIDTH-1:0]] <= push_dat;
        end
    end

endmodule

// File: tb/tb_kahn_sequencer.sv
// Bench for kahn_sequencer: indegree list and adjacency map models, scoreboard fed by a queue-based Kahn model.
module tb_kahn_sequencer;
    localparam int MAXN = 16;
    localparam int NW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kahn_sequencer_if #(.MAX_NODES(MAXN), .NODE_WIDTH(NW)) bus ();

    kahn_sequencer #(.MAX_NODES(MAXN), .NODE_WIDTH(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int node;
        bit last;
    } exp_t;

    typedef struct {
        logic [NW-1:0] data;
        bit            last;
        bit            empty;
    } beat_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   adj[MAXN][$];
    int   indeg0[MAXN];
    int   deg_mem[MAXN];
    bit   load_deg = 1'b0;
    bit   exp_cycle;
    int   exp_emits;
    int   query_cnt = 0;
    bit   stall_mode = 1'b0;
    bit   gap_mode = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Indegree list model: combinational read, decrement on the edge.
    assign bus.indeg_degree = NW'(deg_mem[bus.indeg_node]);
    always @(posedge clk) begin
        if (load_deg) begin
            for (int i = 0; i < MAXN; i++) deg_mem[i] <= indeg0[i];
        end else if (bus.indeg_dec) begin
            deg_mem[bus.indeg_node] <= deg_mem[bus.indeg_node] - 1;
        end
    end

    task automatic clear_graph();
        for (int i = 0; i < MAXN; i++) begin
            adj[i].delete();
            indeg0[i] = 0;
        end
    endtask

    task automatic add_edge(input int u, input int v);
        adj[u].push_back(v);
        indeg0[v]++;
    endtask

    // Reference: plain Kahn with a FIFO, sources in index order, successors in reply order.
    task automatic build_expected(input int n);
        int   d[MAXN];
        int   q[$];
        int   cnt;
        int   v;
        exp_t e;
        cnt = 0;
        for (int i = 0; i < MAXN; i++) d[i] = indeg0[i];
        for (int i = 0; i < n; i++) if (d[i] == 0) q.push_back(i);
        while (q.size() > 0) begin
            v = q.pop_front();
            cnt++;
            e.node = v;
            e.last = (cnt == n);
            sb.push_back(e);
            foreach (adj[v][k]) begin
                d[adj[v][k]]--;
                if (d[adj[v][k]] == 0) q.push_back(adj[v][k]);
            end
        end
        exp_emits = cnt;
        exp_cycle = (cnt != n);
    endtask

    // Adjacency map responder: query handshake sampled before the edge, reply beats driven after it.
    initial begin
        beat_t pend[$];
        beat_t b;
        int    gap;
        int    qwait;
        int    qnode;
        bit    qhs;
        bit    rhs;
        gap = 0;
        qwait = 0;
        bus.query_ready = 1'b0;
        bus.reply_valid = 1'b0;
        bus.reply_data  = '0;
        bus.reply_last  = 1'b0;
        bus.reply_empty = 1'b0;
        forever begin
            @(negedge clk);
            qhs   = bus.query_valid && bus.query_ready;
            qnode = int'(bus.query_data);
            rhs   = bus.reply_valid && bus.reply_ready;
            if (bus.query_valid && !bus.query_ready) qwait++;
            @(posedge clk);
            #1;
            if (rst) begin
                pend.delete();
                gap = 0;
                qwait = 0;
                bus.query_ready = 1'b0;
                bus.reply_valid = 1'b0;
                bus.reply_last  = 1'b0;
                bus.reply_empty = 1'b0;
                continue;
            end
            if (qhs) begin
                query_cnt++;
                qwait = 0;
                if (adj[qnode].size() == 0) begin
                    b.data  = NW'($urandom_range(0, MAXN-1));
                    b.last  = 1'b1;
                    b.empty = 1'b1;
                    pend.push_back(b);
                end else begin
                    foreach (adj[qnode][k]) begin
                        b.data  = NW'(adj[qnode][k]);
                        b.last  = (k == adj[qnode].size() - 1);
                        b.empty = 1'b0;
                        pend.push_back(b);
                    end
                end
            end
            if (rhs && pend.size() > 0) begin
                void'(pend.pop_front());
                gap = gap_mode ? int'($urandom_range(0, 3)) : 0;
            end
            bus.reply_valid = 1'b0;
            if (pend.size() > 0) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    bus.reply_valid = 1'b1;
                    bus.reply_data  = pend[0].data;
                    bus.reply_last  = pend[0].last;
                    bus.reply_empty = pend[0].empty;
                end
            end
            bus.query_ready = stall_mode ? (qwait >= 5) : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard pop on every sorted beat, plus handshake invariants.
    bit            q_stalled = 1'b0;
    logic [NW-1:0] q_prev = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_stalled = 1'b0;
        end else begin
            if (bus.sorted_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sorted_unexpected: got node %0d, expected no output", bus.sorted_node);
                end else begin
                    e = sb.pop_front();
                    check("sorted_node", int'(bus.sorted_node), e.node);
                    check("sorted_last", int'(bus.sorted_last), int'(e.last));
                end
            end
            if (bus.indeg_dec) begin
                check("dec_on_beat", int'(bus.reply_valid && bus.reply_ready && !bus.reply_empty), 1);
                check("dec_node", int'(bus.indeg_node), int'(bus.reply_data));
            end
            if (q_stalled) begin
                check("query_hold_valid", int'(bus.query_valid), 1);
                check("query_hold_data", int'(bus.query_data), int'(q_prev));
            end
            q_stalled = bus.query_valid && !bus.query_ready;
            q_prev    = bus.query_data;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_indeg_node"},   int'(bus.indeg_node), 0);
        check({tag, "_indeg_dec"},    int'(bus.indeg_dec), 0);
        check({tag, "_query_valid"},  int'(bus.query_valid), 0);
        check({tag, "_query_data"},   int'(bus.query_data), 0);
        check({tag, "_reply_ready"},  int'(bus.reply_ready), 0);
        check({tag, "_sorted_valid"}, int'(bus.sorted_valid), 0);
        check({tag, "_sorted_node"},  int'(bus.sorted_node), 0);
        check({tag, "_sorted_last"},  int'(bus.sorted_last), 0);
        check({tag, "_done"},         int'(bus.done), 0);
        check({tag, "_cycle"},        int'(bus.cycle_detected), 0);
    endtask

    task automatic start_run(input int n);
        build_expected(n);
        query_cnt = 0;
        load_deg = 1'b1;
        @(posedge clk);
        #1;
        load_deg = 1'b0;
        bus.node_cnt = (NW+1)'(n);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_run(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.done && cycles < 4000);
        check("done_reached", int'(bus.done), 1);
        check("cycle_detected", int'(bus.cycle_detected), int'(exp_cycle));
        check("sb_drained", sb.size(), 0);
        check("query_count", query_cnt, exp_emits);
        sb.delete();
    endtask

    task automatic run_graph(input int n);
        int cycles;
        start_run(n);
        finish_run(cycles);
    endtask

    initial begin
        int cycles;
        int perm[MAXN];
        int n;
        int t;
        int j;
        int lo;
        int hi;
        bus.start    = 1'b0;
        bus.node_cnt = '0;
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty graph: done one cycle after start, nothing emitted or queried.
        clear_graph();
        start_run(0);
        finish_run(cycles);
        check("empty_done_latency", cycles, 1);

        clear_graph();
        add_edge(0, 1);
        add_edge(1, 2);
        run_graph(3);

        clear_graph();
        add_edge(0, 1);
        add_edge(0, 2);
        add_edge(1, 3);
        add_edge(2, 3);
        run_graph(4);

        clear_graph();
        add_edge(0, 1);
        add_edge(1, 0);
        run_graph(3);

        // Same diamond under query stall and gapped reply beats.
        stall_mode = 1'b1;
        gap_mode   = 1'b1;
        clear_graph();
        add_edge(0, 1);
        add_edge(0, 2);
        add_edge(1, 3);
        add_edge(2, 3);
        run_graph(4);
        stall_mode = 1'b0;
        gap_mode   = 1'b0;

        // Reset while draining the chain, then rerun it.
        clear_graph();
        add_edge(0, 1);
        add_edge(1, 2);
        start_run(3);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.reply_ready && cycles < 200);
        check("drain_reached", int'(bus.reply_ready), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_graph(3);

        // Random graphs, relabelled by a permutation, some duplicates and back edges.
        for (int it = 0; it < 40; it++) begin
            clear_graph();
            n = (it % 8 == 0) ? MAXN : int'($urandom_range(1, MAXN));
            for (int i = 0; i < MAXN; i++) perm[i] = i;
            for (int i = n - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int a = 0; a < n; a++) begin
                for (int c = a + 1; c < n; c++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        add_edge(perm[a], perm[c]);
                        if ($urandom_range(0, 5) == 0 && indeg0[perm[c]] < 15) add_edge(perm[a], perm[c]);
                    end
                end
            end
            if (n >= 2 && $urandom_range(0, 3) == 0) begin
                lo = int'($urandom_range(0, n - 2));
                hi = int'($urandom_range(lo + 1, n - 1));
                if (indeg0[perm[lo]] < 15) add_edge(perm[hi], perm[lo]);
            end
            stall_mode = 1'($urandom_range(0, 1));
            gap_mode   = 1'($urandom_range(0, 1));
            run_graph(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
